game_turn_controller: RTL and testbench
=======================================

// Module: game_turn_controller
// PURPOSE
//   Sequences the two-player VGA obstacle game: owns the game state machine, both
//   scores, the turn hand-over penalty freeze and the frame-locked movement tick.
//   Sits between the hvsync_generator (frame_start) and the player/obstacle
//   position registers (move_tick, freeze). Also drives the score SSDs and state LEDs.
// PARAMETERS
//   TICK_FRAMES    4   frames per move_tick (1..255)
//   FREEZE_FRAMES  30  frames of freeze after each turn hand-over (1..255)
//   WIN_SCORE      10  score that ends the game (1..15)
// PORTS
//   clk          in   1  pixel clock, same clock as hvsync_generator
//   reset        in   1  synchronous, active-high
//   start        in   1  game-enable level from the start switch
//   frame_start  in   1  1-cycle pulse, first cycle of each vertical blank
//   hit          in   1  1-cycle pulse, active player touched an obstacle
//   goal         in   1  1-cycle pulse, active player reached the far edge
//   state        out  2  00 QI, 01 QGAME_1, 10 QGAME_2, 11 QDONE
//   p1_score     out  4  player 1 score
//   p2_score     out  4  player 2 score
//   move_tick    out  1  1-cycle pulse, advance obstacles/player one step
//   freeze       out  1  high during hand-over penalty; position logic holds
//   winner       out  2  00 none, 01 P1, 10 P2; valid in QDONE
// BEHAVIOUR
//   - Reset: state=QI, scores=0, move_tick=0, freeze=0, winner=00, counters=0.
//   - All outputs registered; an event sampled in cycle N is visible in cycle N+1.
//   - QI: scores/winner hold previous values. start==1 -> QGAME_1, clears both
//     scores and winner, frame/freeze counters=0, freeze=0.
//   - QGAME_1/QGAME_2 (active player = 1/2):
//     * frame counter counts frame_start pulses while freeze==0; on the pulse that
//       makes the count TICK_FRAMES, move_tick=1 next cycle and counter -> 0.
//     * goal (freeze==0): active score+1. If new score==WIN_SCORE -> QDONE,
//       winner=active player. Else hand over to other QGAME state.
//     * hit (freeze==0, goal==0): no score change; hand over to other QGAME state.
//     * goal and hit same cycle: goal takes priority, hit ignored.
//     * hand-over: freeze=1, freeze counter loaded FREEZE_FRAMES, frame counter=0;
//       each frame_start decrements; on reaching 0 freeze=0 next cycle.
//     * while freeze==1: hit/goal ignored, move_tick never asserted.
//     * start==0 at any cycle: -> QI, freeze=0, scores kept for display. Takes
//       priority over hit/goal in the same cycle.
//   - QDONE: move_tick=0, freeze=1, scores/winner held. start==0 -> QI.
//     start stays high -> remain in QDONE (no auto-restart).
//   - Scores saturate at WIN_SCORE; never wrap.
//   - reset mid-game overrides everything; next cycle reset values as above.
// TESTING
//   1. reset, start=1, 8 frame_starts, no events -> QGAME_1, move_tick pulses on
//      frames 4 and 8 only, freeze=0, scores 0/0.
//   2. QGAME_1, goal pulse -> p1_score=1, state=QGAME_2, freeze=1 for exactly 30
//      frame_starts, no move_tick and further goal/hit ignored during freeze.
//   3. QGAME_2, hit and goal same cycle -> p2_score+1, single hand-over to QGAME_1.
//   4. Alternate turns with goals until p1_score reaches 10 -> QDONE, winner=01,
//      p1_score stays 10; extra goal pulses have no effect; start 1->0 -> QI.
//   5. QGAME_2 mid-freeze, start=0 -> QI next cycle, freeze=0, scores held;
//      start=1 -> QGAME_1 with scores 0/0.
//   6. reset asserted in QGAME_2 with freeze active -> all outputs at reset values.

Source files
------------

// File: rtl/game_turn_controller.sv
// game_turn_controller: two-player turn FSM with scores, hand-over freeze and frame-locked move tick
module game_turn_controller #(
  parameter int TICK_FRAMES = 4,
  parameter int FREEZE_FRAMES = 30,
  parameter int WIN_SCORE = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_start,
  input  logic       hit,
  input  logic       goal,
  output logic [1:0] state,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic       move_tick,
  output logic       freeze,
  output logic [1:0] winner
);
  typedef enum logic [1:0] {QI, QGAME_1, QGAME_2, QDONE} state_t;
  state_t st, st_n;
  logic [3:0] p1_n, p2_n, act, act_inc;
  logic [1:0] win_n;
  logic       mt_n, frz_n, p2_act;
  logic [7:0] fcnt, fcnt_n, zcnt, zcnt_n;
  assign state = st;
  always_comb begin
    p2_act = st == QGAME_2;
    act = p2_act ? p2_score : p1_score;
    act_inc = act == 4'(WIN_SCORE) ? act : act + 4'd1;
    st_n = st;
    p1_n = p1_score;
    p2_n = p2_score;
    win_n = winner;
    mt_n = 1'b0;
    frz_n = freeze;
    fcnt_n = fcnt;
    zcnt_n = zcnt;
    case (st)
      QI: begin
        frz_n = 1'b0;
        if (start) begin
          st_n = QGAME_1;
          p1_n = '0;
          p2_n = '0;
          win_n = '0;
          fcnt_n = '0;
          zcnt_n = '0;
        end
      end
      QGAME_1, QGAME_2: begin
        if (!start) begin
          st_n = QI;
          frz_n = 1'b0;
          fcnt_n = '0;
          zcnt_n = '0;
        end else if (freeze) begin
          if (frame_start) begin
            zcnt_n = zcnt - 8'd1;
            frz_n = zcnt != 8'd1;
          end
        end else if (goal || hit) begin
          // goal wins over a simultaneous hit; either way the turn ends
          if (goal) begin
            p1_n = p2_act ? p1_score : act_inc;
            p2_n = p2_act ? act_inc : p2_score;
          end
          frz_n = 1'b1;
          fcnt_n = '0;
          if (goal && act_inc == 4'(WIN_SCORE)) begin
            st_n = QDONE;
            win_n = p2_act ? 2'b10 : 2'b01;
          end else begin
            st_n = p2_act ? QGAME_1 : QGAME_2;
            zcnt_n = 8'(FREEZE_FRAMES);
          end
        end else if (frame_start) begin
          mt_n = fcnt == 8'(TICK_FRAMES - 1);
          fcnt_n = mt_n ? 8'd0 : fcnt + 8'd1;
        end
      end
      default: begin
        frz_n = start;
        st_n = start ? QDONE : QI;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= QI;
      p1_score <= '0;
      p2_score <= '0;
      winner <= '0;
      move_tick <= 1'b0;
      freeze <= 1'b0;
      fcnt <= '0;
      zcnt <= '0;
    end else begin
      st <= st_n;
      p1_score <= p1_n;
      p2_score <= p2_n;
      winner <= win_n;
      move_tick <= mt_n;
      freeze <= frz_n;
      fcnt <= fcnt_n;
      zcnt <= zcnt_n;
    end
  end
endmodule

// File: tb/tb_game_turn_controller.sv
// tb_game_turn_controller: scoreboard bench against a turn-level reference model
module tb_game_turn_controller;
  localparam int TICK = 4, FRZ = 30, WIN = 10;
  logic clk = 0, reset = 1, start = 0, frame_start = 0, hit = 0, goal = 0;
  logic [1:0] state, winner;
  logic [3:0] p1_score, p2_score;
  logic move_tick, freeze;
  typedef struct packed {
    logic [1:0] st;
    logic [3:0] p1, p2;
    logic mt, frz;
    logic [1:0] win;
  } exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  int player = 0, sc[3] = '{0, 0, 0}, won = 0, frames = 0, frz_left = 0;
  bit done = 0, tick = 0, frozen = 0;
  game_turn_controller dut (
    .clk(clk), .reset(reset), .start(start), .frame_start(frame_start),
    .hit(hit), .goal(goal), .state(state), .p1_score(p1_score),
    .p2_score(p2_score), .move_tick(move_tick), .freeze(freeze), .winner(winner)
  );
  always #5 clk = ~clk;
  // player: 0 idle, 1/2 whose turn it is; done marks a finished game
  function automatic logic [1:0] model_state();
    return done ? 2'd3 : 2'(player);
  endfunction
  task automatic model_step(input bit r, s, f, h, g);
    tick = 0;
    if (r) begin
      player = 0; done = 0; sc = '{0, 0, 0}; won = 0; frames = 0; frz_left = 0; frozen = 0;
    end else if (done) begin
      if (!s) begin done = 0; player = 0; frozen = 0; end
    end else if (player == 0) begin
      if (s) begin player = 1; sc = '{0, 0, 0}; won = 0; frames = 0; frozen = 0; end
    end else if (!s) begin
      player = 0; frozen = 0; frames = 0;
    end else if (frozen) begin
      if (f) begin frz_left--; if (frz_left == 0) frozen = 0; end
    end else if (g || h) begin
      if (g && sc[player] < WIN) sc[player]++;
      frozen = 1; frames = 0;
      if (g && sc[player] == WIN) begin done = 1; won = player; end
      else begin player = 3 - player; frz_left = FRZ; end
    end else if (f) begin
      frames++;
      if (frames == TICK) begin tick = 1; frames = 0; end
    end
  endtask
  task automatic cyc(input bit r, s, f, h, g);
    exp_t e;
    @(negedge clk);
    reset = r; start = s; frame_start = f; hit = h; goal = g;
    model_step(r, s, f, h, g);
    e.st = model_state(); e.p1 = 4'(sc[1]); e.p2 = 4'(sc[2]);
    e.mt = tick; e.frz = frozen; e.win = 2'(won);
    q.push_back(e);
  endtask
  task automatic frames_n(input int n);
    for (int i = 0; i < n; i++) begin cyc(0, 1, 1, 0, 0); cyc(0, 1, 0, 0, 0); end
  endtask
  initial begin : monitor
    exp_t e, a;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {state, p1_score, p2_score, move_tick, freeze, winner};
        compared++;
        if (a !== e) begin
          mismatched++;
          $display("FAIL outputs t=%0t got st=%0d p1=%0d p2=%0d mt=%0b frz=%0b win=%0d want st=%0d p1=%0d p2=%0d mt=%0b frz=%0b win=%0d",
            $time, a.st, a.p1, a.p2, a.mt, a.frz, a.win, e.st, e.p1, e.p2, e.mt, e.frz, e.win);
        end
      end
    end
  end
  initial begin
    int x;
    bit r, s;
    repeat (2) cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin cyc(0, 1, 1, 0, 0); repeat (3) cyc(0, 1, 0, 0, 0); end
    cyc(0, 1, 0, 0, 1);
    for (int i = 0; i < FRZ; i++) begin
      cyc(0, 1, 1, 0, 0);
      if (i < FRZ - 1) cyc(0, 1, 0, i % 2, (i + 1) % 2);
    end
    frames_n(5);
    cyc(0, 1, 0, 1, 1);
    frames_n(FRZ + 1);
    for (int k = 0; k < 40 && !done; k++) begin cyc(0, 1, 0, 0, 1); frames_n(FRZ); end
    repeat (3) cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    frames_n(5);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    frames_n(3);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      x = int'($urandom % 12);
      r = $urandom % 700 == 0;
      s = $urandom % 400 != 0;
      cyc(r, s, x < 5, x == 5 || x == 8, x == 6 || x == 7 || x == 8);
    end
    cyc(0, 1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
